sb_spi_bus_master: RTL and testbench
====================================

Name: sb_spi_bus_master

Overview:
Drives the system-bus (SB) register interface of the iCE40 hard SPI primitive on the FPGA-side bus.
- Converts a byte-stream valid/ready interface into SB register accesses: init, chip-select, TX write, status poll, RX read.
- Sits directly upstream of the SB_SPI instance; its sb_* outputs connect 1:1 to the primitive's SB* pins.
- Returns each received byte on a one-cycle-valid RX strobe.

Parameters:
BUS_ADDR74, 4'b0000, SB address high nibble; must match the primitive's BUS_ADDR74.
CR1_VAL, 8'h80, SPICR1 init value (SPE=1).
CR2_VAL, 8'hC0, SPICR2 init value (MSTR=1, MCSH=1, mode 0, MSB first).
BR_VAL, 8'h05, SPIBR init value (SCK divider).
CS_MASK, 4'b1110, SPICSR value written while selected (CS0 active-low).
TIMEOUT_CYCLES, 1023, ack watchdog limit (optional feature only).

Ports:
clk  in  1  system clock; also drives the primitive's SBCLKI
reset  in  1  synchronous, active-high reset
tx_valid  in  1  byte available
tx_ready  out  1  byte accepted this cycle when tx_valid=1
tx_data  in  8  byte to shift out
tx_last  in  1  release CS after this byte
rx_valid  out  1  one-cycle strobe, rx_data valid
rx_data  out  8  received byte
busy  out  1  1 from init until return to IDLE
error  out  1  sticky ack-timeout flag (optional feature only; else tied 0)
sb_stb  out  1  to SBSTBI
sb_rw  out  1  to SBRWI; 1=write
sb_adr  out  8  to SBADRI7..0
sb_dat_o  out  8  to SBDATI7..0
sb_dat_i  in  8  from SBDATO7..0
sb_ack  in  1  from SBACKO

Behaviour:
- Register addresses: {BUS_ADDR74, low nibble}.
  - Low nibbles: CR1=9, CR2=A, BR=B, SR=C, TXDR=D, RXDR=E, CSR=F.
- SB cycle:
  - Assert sb_stb with sb_adr, sb_rw and sb_dat_o stable; hold until sb_ack=1.
  - On the ack cycle, capture sb_dat_i for reads.
  - Drop sb_stb for exactly 1 cycle before any next access.
- Reset values: sb_stb=0, sb_rw=0, sb_adr=0, sb_dat_o=0, tx_ready=0, rx_valid=0, rx_data=0, busy=1, error=0. State=INIT_CR1.
- States and transitions:
  - INIT_CR1 -> INIT_CR2 -> INIT_BR: one write each (CR1_VAL, CR2_VAL, BR_VAL), then IDLE.
  - IDLE: busy=0, tx_ready=1. On tx_valid, latch tx_data and tx_last, go to CS_ON.
  - CS_ON: write CS_MASK to CSR. Skipped when CS is already asserted from an unfinished frame (tx_last was 0).
  - POLL_TRDY: read SR; repeat until bit4 (TRDY)=1.
  - WR_TX: write latched byte to TXDR.
  - POLL_RRDY: read SR; repeat until bit3 (RRDY)=1.
  - RD_RX: read RXDR. On ack: rx_data<=sb_dat_i, rx_valid=1 the next cycle.
  - After RD_RX: if latched last=1, go to CS_OFF, else IDLE.
  - CS_OFF: write 4'hF (upper nibble 0) to CSR, then IDLE.
- tx_ready is high only in IDLE; there is no skid buffer. Throughput is one byte per full sequence.
- Back-to-back bytes with tx_last=0 keep CS asserted; CSR is not rewritten.
- sb_ack arriving while sb_stb=0 is ignored.
- Reset asserted mid-transaction aborts the SB cycle the same cycle (sb_stb=0) and restarts INIT. CS is not explicitly released; the primitive's own reset handles it.
- rx_valid is never asserted in the same cycle as tx_ready accepting a new byte.
  - Exception: IDLE entered from RD_RX may accept in the same cycle rx_valid pulses; this is allowed and the bench must tolerate it.

Optional Feature:
SB_SPI_BUS_MASTER_TIMEOUT_EN
- Defined: a 10-bit counter runs while sb_stb=1 and sb_ack=0.
  - When it reaches TIMEOUT_CYCLES: drop sb_stb, set error=1 (sticky until reset), go to IDLE, discard the in-flight byte, emit no rx_valid.
  - CS state is tracked as released.
- Undefined: no counter; error is constant 0; waits on ack indefinitely.

Test Plan:
- Reset release, ack each strobe after 2 cycles -> writes observed in order: adr 0x09 dat 0x80, 0x0A 0xC0, 0x0B 0x05; then busy=0, tx_ready=1.
- Send 0xA5 with tx_last=1; SR model returns 0x10 then 0x08; RXDR returns 0x3C -> expected access sequence:
  - CSR write 0x0E, SR read, TXDR write 0xA5, SR read, RXDR read.
  - rx_valid pulse with rx_data=0x3C, then CSR write 0x0F.
- Two bytes 0x01 (tx_last=0) then 0x02 (tx_last=1) -> exactly one CSR 0x0E write before byte 1 and one CSR 0x0F write after byte 2; rx_valid pulses twice.
- SR returns 0x00 five times before RRDY -> five extra SR reads issued; each access is separated by a 1-cycle sb_stb low gap.
- Assert reset during POLL_RRDY -> sb_stb=0 next edge; init sequence replays starting at adr 0x09.
- With SB_SPI_BUS_MASTER_TIMEOUT_EN defined, withhold ack on the TXDR write for 1023 cycles -> error=1, sb_stb=0, IDLE, no rx_valid.
  - Without the macro, the same stimulus holds sb_stb=1 and error stays 0.

Source files
------------

// File: rtl/sb_spi_bus_master_if.sv
// sb_spi_bus_master_if
//   Groups the byte-stream handshake and the SB register bus of the
//   iCE40 SB_SPI primitive into one bundle.
//   master modport: the bus-master side (consumes TX bytes, produces RX
//                   strobes, drives SB strobe/address/data).
//   slave modport : the opposite side (byte source plus SB primitive).
//   Signals:
//     tx_valid/tx_ready/tx_data/tx_last : byte stream into the master
//     rx_valid/rx_data                  : one-cycle RX strobe out
//     sb_stb/sb_rw/sb_adr/sb_dat_o      : to SBSTBI/SBRWI/SBADRI/SBDATI
//     sb_dat_i/sb_ack                   : from SBDATO/SBACKO
interface sb_spi_bus_master_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       sb_stb;
  logic       sb_rw;
  logic [7:0] sb_adr;
  logic [7:0] sb_dat_o;
  logic [7:0] sb_dat_i;
  logic       sb_ack;

  modport master (
    input  tx_valid, tx_data, tx_last, sb_dat_i, sb_ack,
    output tx_ready, rx_valid, rx_data, sb_stb, sb_rw, sb_adr, sb_dat_o
  );

  modport slave (
    output tx_valid, tx_data, tx_last, sb_dat_i, sb_ack,
    input  tx_ready, rx_valid, rx_data, sb_stb, sb_rw, sb_adr, sb_dat_o
  );
endinterface

// File: rtl/sb_spi_bus_master.sv
// sb_spi_bus_master
//   Drives the SB register interface of the iCE40 hard SPI primitive:
//   initialises CR1/CR2/BR, then for every streamed byte asserts CS,
//   polls TRDY, writes TXDR, polls RRDY, reads RXDR and optionally
//   releases CS. Every SB access is followed by one cycle of sb_stb low.
//   Ports:
//     clk   : system clock (also the primitive's SBCLKI)
//     reset : synchronous, active-high
//     bus   : sb_spi_bus_master_if.master (byte stream + SB bus)
//     busy  : high from init until the FSM rests in IDLE
//     error : sticky ack-timeout flag (0 unless the timeout is built in)
//   Optional feature macro: SB_SPI_BUS_MASTER_TIMEOUT_EN enables an ack
//   watchdog of TIMEOUT_CYCLES cycles.
module sb_spi_bus_master #(
`ifdef SB_SPI_BUS_MASTER_TIMEOUT_EN
  parameter int         TIMEOUT_CYCLES = 1023,
`endif
  parameter logic [3:0] BUS_ADDR74 = 4'b0000,
  parameter logic [7:0] CR1_VAL    = 8'h80,
  parameter logic [7:0] CR2_VAL    = 8'hC0,
  parameter logic [7:0] BR_VAL     = 8'h05,
  parameter logic [3:0] CS_MASK    = 4'b1110
) (
  input  logic                       clk,
  input  logic                       reset,
  sb_spi_bus_master_if.master        bus,
  output logic                       busy,
  output logic                       error
);

  typedef enum logic [3:0] {
    INIT_CR1, INIT_CR2, INIT_BR, IDLE, CS_ON,
    POLL_TRDY, WR_TX, POLL_RRDY, RD_RX, CS_OFF
  } state_t;

  state_t     state_r, state_n;
  logic       stb_r, stb_n, rw_r, rw_n;
  logic [7:0] adr_r, adr_n, dat_r, dat_n;
  logic       rx_valid_r, rx_valid_n;
  logic [7:0] rx_data_r, rx_data_n;
  logic [7:0] byte_r, byte_n;
  logic       last_r, last_n, cs_r, cs_n;
  logic       error_r, error_n;
  logic       tx_ready_r, busy_r;
  logic       tmo_hit_s;
  logic [3:0] acc_lo_s;
  logic       acc_rw_s;
  logic [7:0] acc_dat_s;

`ifdef SB_SPI_BUS_MASTER_TIMEOUT_EN
  localparam logic [9:0] TMO_LIMIT = 10'(TIMEOUT_CYCLES);
  logic [9:0] tmo_cnt_r;

  // Ack watchdog: counts cycles the strobe waits without an ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_r <= 10'd0;
    end else if (stb_r && !bus.sb_ack) begin
      tmo_cnt_r <= tmo_cnt_r + 10'd1;
    end else begin
      tmo_cnt_r <= 10'd0;
    end
  end

  assign tmo_hit_s = stb_r && !bus.sb_ack && (tmo_cnt_r == TMO_LIMIT);
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Per-state SB access descriptor (address low nibble, direction, data).
  always_comb begin
    acc_lo_s  = 4'h0;
    acc_rw_s  = 1'b0;
    acc_dat_s = 8'h00;
    case (state_r)
      INIT_CR1:  begin acc_lo_s = 4'h9; acc_rw_s = 1'b1; acc_dat_s = CR1_VAL;          end
      INIT_CR2:  begin acc_lo_s = 4'hA; acc_rw_s = 1'b1; acc_dat_s = CR2_VAL;          end
      INIT_BR:   begin acc_lo_s = 4'hB; acc_rw_s = 1'b1; acc_dat_s = BR_VAL;           end
      CS_ON:     begin acc_lo_s = 4'hF; acc_rw_s = 1'b1; acc_dat_s = {4'h0, CS_MASK};  end
      POLL_TRDY: begin acc_lo_s = 4'hC; acc_rw_s = 1'b0; acc_dat_s = 8'h00;            end
      WR_TX:     begin acc_lo_s = 4'hD; acc_rw_s = 1'b1; acc_dat_s = byte_r;           end
      POLL_RRDY: begin acc_lo_s = 4'hC; acc_rw_s = 1'b0; acc_dat_s = 8'h00;            end
      RD_RX:     begin acc_lo_s = 4'hE; acc_rw_s = 1'b0; acc_dat_s = 8'h00;            end
      CS_OFF:    begin acc_lo_s = 4'hF; acc_rw_s = 1'b1; acc_dat_s = 8'h0F;            end
      default:   begin acc_lo_s = 4'h0; acc_rw_s = 1'b0; acc_dat_s = 8'h00;            end
    endcase
  end

  // Next-state and next-output logic. An access state first spends one
  // cycle with sb_stb low (the inter-access gap), then raises the strobe
  // and holds it until ack; on ack the strobe drops and the state moves.
  always_comb begin
    state_n    = state_r;
    stb_n      = stb_r;
    rw_n       = rw_r;
    adr_n      = adr_r;
    dat_n      = dat_r;
    rx_valid_n = 1'b0;
    rx_data_n  = rx_data_r;
    byte_n     = byte_r;
    last_n     = last_r;
    cs_n       = cs_r;
    error_n    = error_r;
    if (state_r == IDLE) begin
      if (bus.tx_valid) begin
        byte_n  = bus.tx_data;
        last_n  = bus.tx_last;
        // CS is still asserted from an unfinished frame: skip the CSR write.
        state_n = cs_r ? POLL_TRDY : CS_ON;
      end else begin
        state_n = IDLE;
      end
    end else if (!stb_r) begin
      stb_n = 1'b1;
      rw_n  = acc_rw_s;
      adr_n = {BUS_ADDR74, acc_lo_s};
      dat_n = acc_dat_s;
    end else if (bus.sb_ack) begin
      stb_n = 1'b0;
      case (state_r)
        INIT_CR1:  state_n = INIT_CR2;
        INIT_CR2:  state_n = INIT_BR;
        INIT_BR:   state_n = IDLE;
        CS_ON:     begin state_n = POLL_TRDY; cs_n = 1'b1; end
        POLL_TRDY: state_n = bus.sb_dat_i[4] ? WR_TX : POLL_TRDY;
        WR_TX:     state_n = POLL_RRDY;
        POLL_RRDY: state_n = bus.sb_dat_i[3] ? RD_RX : POLL_RRDY;
        RD_RX: begin
          rx_valid_n = 1'b1;
          rx_data_n  = bus.sb_dat_i;
          state_n    = last_r ? CS_OFF : IDLE;
        end
        CS_OFF:    begin state_n = IDLE; cs_n = 1'b0; end
        default:   state_n = IDLE;
      endcase
    end else if (tmo_hit_s) begin
      // Abandon the access and the byte; the primitive's CS is treated as
      // released so the next byte starts a fresh frame.
      stb_n   = 1'b0;
      error_n = 1'b1;
      cs_n    = 1'b0;
      state_n = IDLE;
    end else begin
      stb_n = 1'b1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= INIT_CR1;
      stb_r      <= 1'b0;
      rw_r       <= 1'b0;
      adr_r      <= 8'h00;
      dat_r      <= 8'h00;
      rx_valid_r <= 1'b0;
      rx_data_r  <= 8'h00;
      byte_r     <= 8'h00;
      last_r     <= 1'b0;
      cs_r       <= 1'b0;
      error_r    <= 1'b0;
      tx_ready_r <= 1'b0;
      busy_r     <= 1'b1;
    end else begin
      state_r    <= state_n;
      stb_r      <= stb_n;
      rw_r       <= rw_n;
      adr_r      <= adr_n;
      dat_r      <= dat_n;
      rx_valid_r <= rx_valid_n;
      rx_data_r  <= rx_data_n;
      byte_r     <= byte_n;
      last_r     <= last_n;
      cs_r       <= cs_n;
      error_r    <= error_n;
      tx_ready_r <= (state_n == IDLE);
      busy_r     <= (state_n != IDLE);
    end
  end

  assign bus.sb_stb   = stb_r;
  assign bus.sb_rw    = rw_r;
  assign bus.sb_adr   = adr_r;
  assign bus.sb_dat_o = dat_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.tx_ready = tx_ready_r;
  assign busy         = busy_r;
  assign error        = error_r;

endmodule

// File: tb/tb_sb_spi_bus_master.sv
// tb_sb_spi_bus_master
//   Directed bench for sb_spi_bus_master. An SB slave model acks every
//   strobe two cycles after it rises, logs each access (direction,
//   address, data, preceding low-gap length) and answers SR / RXDR reads
//   from bench-controlled values. Scenario tasks compare the log and the
//   RX strobes with hand-written expected sequences.
module tb_sb_spi_bus_master;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy, error;
  int   errors = 0;
  int   checks = 0;

  sb_spi_bus_master_if bus();

  sb_spi_bus_master dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .error (error)
  );

  always #5 clk = ~clk;

  // SB slave model state and access log
  logic [7:0] sr_q[$];
  logic [7:0] rx_resp = 8'h00;
  bit         hold_tx = 1'b0;
  int         wait_cnt = 0;
  int         gap_cnt = 0;
  bit         log_rw[$];
  logic [7:0] log_adr[$];
  logic [7:0] log_dat[$];
  int         log_gap[$];
  logic [7:0] rx_q[$];

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_last  = 1'b0;
    bus.sb_ack   = 1'b0;
    bus.sb_dat_i = 8'h00;
  end

  // Slave model and RX monitor, evaluated on the falling edge.
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) rx_q.push_back(bus.rx_data);
    if (reset || !bus.sb_stb) begin
      bus.sb_ack = 1'b0;
      wait_cnt   = 0;
      if (!bus.sb_stb) gap_cnt++;
    end else if (!bus.sb_ack) begin
      wait_cnt++;
      if (wait_cnt >= 2 && !(hold_tx && bus.sb_rw && bus.sb_adr[3:0] == 4'hD)) begin
        if (bus.sb_adr[3:0] == 4'hC)
          bus.sb_dat_i = (sr_q.size() > 0) ? sr_q.pop_front() : 8'h18;
        else if (bus.sb_adr[3:0] == 4'hE)
          bus.sb_dat_i = rx_resp;
        else
          bus.sb_dat_i = 8'h00;
        bus.sb_ack = 1'b1;
        log_rw.push_back(bus.sb_rw);
        log_adr.push_back(bus.sb_adr);
        log_dat.push_back(bus.sb_dat_o);
        log_gap.push_back(gap_cnt);
        gap_cnt = 0;
      end
    end else begin
      bus.sb_ack = 1'b0;
    end
  end

  task automatic clear_log();
    log_rw.delete(); log_adr.delete(); log_dat.delete(); log_gap.delete();
    rx_q.delete();
  endtask

  task automatic wait_ready(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.tx_ready === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_wait_ready: tx_ready never rose (actual 0, required 1)", name);
    end
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic last, input string name);
    wait_ready(name);
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    bus.tx_last  = last;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    clear_log();
    checks += 9;
    if (bus.sb_stb !== 1'b0)     begin errors++; $display("FAIL rst_stb: got %b want 0", bus.sb_stb); end
    if (bus.sb_rw !== 1'b0)      begin errors++; $display("FAIL rst_rw: got %b want 0", bus.sb_rw); end
    if (bus.sb_adr !== 8'h00)    begin errors++; $display("FAIL rst_adr: got %h want 00", bus.sb_adr); end
    if (bus.sb_dat_o !== 8'h00)  begin errors++; $display("FAIL rst_dat: got %h want 00", bus.sb_dat_o); end
    if (bus.tx_ready !== 1'b0)   begin errors++; $display("FAIL rst_tx_ready: got %b want 0", bus.tx_ready); end
    if (bus.rx_valid !== 1'b0)   begin errors++; $display("FAIL rst_rx_valid: got %b want 0", bus.rx_valid); end
    if (bus.rx_data !== 8'h00)   begin errors++; $display("FAIL rst_rx_data: got %h want 00", bus.rx_data); end
    if (busy !== 1'b1)           begin errors++; $display("FAIL rst_busy: got %b want 1", busy); end
    if (error !== 1'b0)          begin errors++; $display("FAIL rst_error: got %b want 0", error); end
    reset = 1'b0;
    wait_ready("init");
    begin
      logic [7:0] ea[3] = '{8'h09, 8'h0A, 8'h0B};
      logic [7:0] ed[3] = '{8'h80, 8'hC0, 8'h05};
      checks++;
      if (log_adr.size() != 3) begin errors++; $display("FAIL init_count: got %0d want 3", log_adr.size()); end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (log_rw[i] !== 1'b1 || log_adr[i] !== ea[i] || log_dat[i] !== ed[i]) begin
          errors++;
          $display("FAIL init_seq[%0d]: got rw=%b adr=%h dat=%h want rw=1 adr=%h dat=%h",
                   i, log_rw[i], log_adr[i], log_dat[i], ea[i], ed[i]);
        end
      end
    end
    checks += 2;
    if (busy !== 1'b0)         begin errors++; $display("FAIL init_busy: got %b want 0", busy); end
    if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL init_tx_ready: got %b want 1", bus.tx_ready); end
  endtask

  task automatic test_single();
    logic [7:0] ea[6] = '{8'h0F, 8'h0C, 8'h0D, 8'h0C, 8'h0E, 8'h0F};
    bit         er[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] ed[6] = '{8'h0E, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h0F};
    clear_log();
    sr_q = '{8'h10, 8'h08};
    rx_resp = 8'h3C;
    drive_byte(8'hA5, 1'b1, "single");
    wait_ready("single");
    checks++;
    if (log_adr.size() != 6) begin errors++; $display("FAIL single_count: got %0d want 6", log_adr.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (log_rw[i] !== er[i] || log_adr[i] !== ea[i] || (er[i] && log_dat[i] !== ed[i]) ||
          (i > 0 && log_gap[i] != 1)) begin
        errors++;
        $display("FAIL single_seq[%0d]: got rw=%b adr=%h dat=%h gap=%0d want rw=%b adr=%h dat=%h gap=1",
                 i, log_rw[i], log_adr[i], log_dat[i], log_gap[i], er[i], ea[i], ed[i]);
      end
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
      errors++;
      $display("FAIL single_rx: got %0d strobes first=%h want 1 strobe 3c", rx_q.size(), rx_q[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ea[10] = '{8'h0F, 8'h0C, 8'h0D, 8'h0C, 8'h0E, 8'h0C, 8'h0D, 8'h0C, 8'h0E, 8'h0F};
    bit         er[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] ed[10] = '{8'h0E, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h0F};
    clear_log();
    rx_resp = 8'h11;
    drive_byte(8'h01, 1'b0, "b2b1");
    wait_ready("b2b1");
    rx_resp = 8'h22;
    drive_byte(8'h02, 1'b1, "b2b2");
    wait_ready("b2b2");
    checks++;
    if (log_adr.size() != 10) begin errors++; $display("FAIL b2b_count: got %0d want 10", log_adr.size()); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (log_rw[i] !== er[i] || log_adr[i] !== ea[i] || (er[i] && log_dat[i] !== ed[i])) begin
        errors++;
        $display("FAIL b2b_seq[%0d]: got rw=%b adr=%h dat=%h want rw=%b adr=%h dat=%h",
                 i, log_rw[i], log_adr[i], log_dat[i], er[i], ea[i], ed[i]);
      end
    end
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h11 || rx_q[1] !== 8'h22) begin
      errors++;
      $display("FAIL b2b_rx: got %0d strobes %h %h want 2 strobes 11 22", rx_q.size(), rx_q[0], rx_q[1]);
    end
  endtask

  task automatic test_poll();
    int sr_reads = 0;
    clear_log();
    sr_q = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08};
    rx_resp = 8'h5A;
    drive_byte(8'h5A, 1'b1, "poll");
    wait_ready("poll");
    checks++;
    if (log_adr.size() != 11) begin errors++; $display("FAIL poll_count: got %0d want 11", log_adr.size()); end
    foreach (log_adr[i]) if (log_adr[i] == 8'h0C && log_rw[i] == 1'b0) sr_reads++;
    checks++;
    if (sr_reads != 7) begin errors++; $display("FAIL poll_sr_reads: got %0d want 7", sr_reads); end
    for (int i = 1; i < 11; i++) begin
      checks++;
      if (log_gap[i] != 1) begin
        errors++;
        $display("FAIL poll_gap[%0d]: got %0d want 1", i, log_gap[i]);
      end
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h5A) begin
      errors++;
      $display("FAIL poll_rx: got %0d strobes first=%h want 1 strobe 5a", rx_q.size(), rx_q[0]);
    end
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    clear_log();
    sr_q = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    drive_byte(8'hC3, 1'b1, "mid");
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (log_adr.size() >= 5 && bus.sb_stb === 1'b1) begin hit = 1'b1; break; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL mid_reach_poll: POLL_RRDY strobe not seen (actual 0, required 1)"); end
    reset = 1'b1;
    @(negedge clk);
    checks += 2;
    if (bus.sb_stb !== 1'b0) begin errors++; $display("FAIL mid_stb_drop: got %b want 0", bus.sb_stb); end
    if (busy !== 1'b1)       begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
    sr_q.delete();
    clear_log();
    reset = 1'b0;
    wait_ready("mid");
    checks += 2;
    if (log_adr.size() != 3) begin errors++; $display("FAIL mid_init_count: got %0d want 3", log_adr.size()); end
    if (log_adr[0] !== 8'h09 || log_dat[0] !== 8'h80) begin
      errors++;
      $display("FAIL mid_init_first: got adr=%h dat=%h want adr=09 dat=80", log_adr[0], log_dat[0]);
    end
    checks++;
    if (rx_q.size() != 0) begin errors++; $display("FAIL mid_rx: got %0d strobes want 0", rx_q.size()); end
  endtask

  task automatic test_timeout();
    bit hit = 1'b0;
    clear_log();
    hold_tx = 1'b1;
    drive_byte(8'h77, 1'b1, "tmo");
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.sb_stb === 1'b1 && bus.sb_rw === 1'b1 && bus.sb_adr === 8'h0D) begin hit = 1'b1; break; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL tmo_reach_tx: TXDR strobe not seen (actual 0, required 1)"); end
`ifdef SB_SPI_BUS_MASTER_TIMEOUT_EN
    hit = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (error === 1'b1) begin hit = 1'b1; break; end
    end
    checks += 4;
    if (!hit)                  begin errors++; $display("FAIL tmo_error: got %b want 1", error); end
    if (bus.sb_stb !== 1'b0)   begin errors++; $display("FAIL tmo_stb: got %b want 0", bus.sb_stb); end
    if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL tmo_idle: got tx_ready=%b want 1", bus.tx_ready); end
    if (rx_q.size() != 0)      begin errors++; $display("FAIL tmo_rx: got %0d strobes want 0", rx_q.size()); end
`else
    repeat (1100) @(negedge clk);
    checks += 3;
    if (bus.sb_stb !== 1'b1) begin errors++; $display("FAIL tmo_stb_held: got %b want 1", bus.sb_stb); end
    if (error !== 1'b0)      begin errors++; $display("FAIL tmo_error: got %b want 0", error); end
    if (rx_q.size() != 0)    begin errors++; $display("FAIL tmo_rx: got %0d strobes want 0", rx_q.size()); end
`endif
    hold_tx = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_poll();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
